// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional burst-hold priority is built when FIFO_ARB_BURST_EN is defined.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [7:0]                    ovf_count
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_param_check
        $error("fifo_wr_arb: NUM_REQ must be 2..8 and MAX_BURST >= 1");
    end

    logic [FIFO_WIDTH-1:0] data_arr [NUM_REQ];
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        idx;
    logic [IDW-1:0]        ptr_inc;
    logic                  any_valid;
    logic                  can_accept;
    logic                  take;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // A write already on the pins consumes the last free slot.
    assign can_accept = !fifo_full && !(fifo_almostfull && wr_en);

    always_comb begin
        winner    = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    assign take    = any_valid && can_accept;
    assign ptr_inc = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (take && rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0]  burst_cnt;
    logic [CW-1:0]  burst_new;
    logic [IDW-1:0] ptr_adv;

    // Continuing a burst only when the pointer's owner wins again.
    assign burst_new = (winner == rr_ptr) ? burst_cnt + CW'(1) : CW'(1);
    assign ptr_adv   = (rr_ptr == IDW'(NUM_REQ - 1)) ? '0 : rr_ptr + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (take) begin
            if (burst_new >= CW'(MAX_BURST)) begin
                rr_ptr    <= ptr_inc;
                burst_cnt <= '0;
            end else begin
                rr_ptr    <= winner;
                burst_cnt <= burst_new;
            end
        end else if (can_accept && burst_cnt != '0) begin
            rr_ptr    <= ptr_adv;
            burst_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= ptr_inc;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            data_in  <= '0;
            grant_id <= '0;
        end else begin
            wr_en <= take;
            if (take) begin
                data_in  <= data_arr[winner];
                grant_id <= winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (fifo_overflow && ovf_count != 8'hFF) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (default parameters).
// Burst-mode expectations are selected when FIFO_ARB_BURST_EN is defined.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_almostfull;
    logic        fifo_overflow;
    logic        wr_en;
    logic [15:0] data_in;
    logic [1:0]  grant_id;
    logic [7:0]  ovf_count;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_ARB_BURST_EN
    localparam int RR_BEATS   = 8;
    localparam int EXP_FULL_K = 2;
`else
    localparam int RR_BEATS   = 6;
    localparam int EXP_FULL_K = 3;
`endif

    logic [15:0] pdata [4];

    fifo_wr_arb #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_overflow   (fifo_overflow),
        .wr_en           (wr_en),
        .data_in         (data_in),
        .grant_id        (grant_id),
        .ovf_count       (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        pdata[0] = 16'h1111;
        pdata[1] = 16'h2222;
        pdata[2] = 16'h3333;
        pdata[3] = 16'h4444;
        req_data        = {pdata[3], pdata[2], pdata[1], pdata[0]};
        rst_n           = 1'b0;
        req_valid       = 4'b1111;
        fifo_full       = 1'b0;
        fifo_almostfull = 1'b0;
        fifo_overflow   = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;

        // all producers valid, FIFO empty
        for (int c = 0; c < RR_BEATS; c++) begin
`ifdef FIFO_ARB_BURST_EN
            k = (c / 4) % 4;
`else
            k = c % 4;
`endif
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << k));
            tick();
            chk("rr_wr_en", 32'(wr_en), 32'd1);
            chk("rr_grant", 32'(grant_id), 32'(k));
            chk("rr_data", 32'(data_in), 32'(pdata[k]));
        end

        // almost-full with a write on the pins blocks everyone
        fifo_almostfull = 1'b1;
        #1;
        chk("af_ready_blocked", 32'(req_ready), 32'd0);
        tick();
        chk("af_wr_en_idle", 32'(wr_en), 32'd0);
        chk("af_grant_hold", 32'(grant_id), 32'd1);
        chk("af_data_hold", 32'(data_in), 32'(pdata[1]));
        chk("af_ready_free", 32'(req_ready), 32'b0100);
        tick();
        chk("af_last_write", 32'(wr_en), 32'd1);
        chk("af_last_grant", 32'(grant_id), 32'd2);
        chk("af_ready_drop", 32'(req_ready), 32'd0);

        // full stalls and holds the pointer
        fifo_almostfull = 1'b0;
        fifo_full       = 1'b1;
        #1;
        chk("full_ready", 32'(req_ready), 32'd0);
        tick();
        chk("full_wr_en", 32'(wr_en), 32'd0);
        chk("full_grant_hold", 32'(grant_id), 32'd2);
        tick();
        fifo_full = 1'b0;
        #1;
        chk("full_ptr_hold", 32'(req_ready), 32'(4'b0001 << EXP_FULL_K));
        tick();
        chk("full_resume_grant", 32'(grant_id), 32'(EXP_FULL_K));
        chk("full_resume_wr_en", 32'(wr_en), 32'd1);

        // single producer
        req_data[32 +: 16] = 16'hA5A5;
        req_valid = 4'b0100;
        #1;
        chk("solo_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("solo_wr_en", 32'(wr_en), 32'd1);
        chk("solo_data", 32'(data_in), 32'hA5A5);
        chk("solo_grant", 32'(grant_id), 32'd2);
        req_valid = 4'b0000;
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'd0);
        chk("idle_data_hold", 32'(data_in), 32'hA5A5);

        // reset mid-transfer
        req_valid = 4'b1111;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("pre_rst_grant", 32'(grant_id), 32'd3);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_data", 32'(data_in), 32'd0);
        chk("mid_rst_grant", 32'(grant_id), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

        // overflow counter saturation
        fifo_overflow = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_10", 32'(ovf_count), 32'd10);
        repeat (290) @(posedge clk);
        #1;
        chk("ovf_sat", 32'(ovf_count), 32'd255);
        fifo_overflow = 1'b0;
        tick();
        chk("ovf_hold", 32'(ovf_count), 32'd255);

`ifdef FIFO_ARB_BURST_EN
        // burst: producer 1 drops valid after two beats
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 6; c++) begin
            k = (c < 4) ? 0 : 1;
            tick();
            chk("burst_grant", 32'(grant_id), 32'(k));
        end
        req_valid = 4'b1101;
        #1;
        chk("burst_drop_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("burst_drop_grant", 32'(grant_id), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
